// File: rtl/qracc_actbuf_arbiter.sv
// Two-requester arbiter in front of the activation-buffer SRAM: int has priority,
// ext is forced a grant after STARVE_LIMIT consecutive lost cycles.
module qracc_actbuf_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear_i,
    input  logic              ext_only_i,

    input  logic              ext_valid_i,
    output logic              ext_ready_o,
    input  logic              ext_wen_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic              ext_rvalid_o,

    input  logic              int_valid_i,
    output logic              int_ready_o,
    input  logic              int_wen_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    input  logic [DATA_W-1:0] int_wdata_i,
    output logic [DATA_W-1:0] int_rdata_o,
    output logic              int_rvalid_o,

    output logic              mem_en_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic [15:0]       conflict_cnt_o,
    output logic              state_o
);

    // Handshake: a transfer happens in a cycle where valid && ready; ready is
    // only ever raised towards a requester whose valid is already high, so a
    // grant and a handshake are the same event.

    typedef enum logic {
        S_INT_PRIO   = 1'b0,
        S_EXT_FORCED = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        tag_valid_q, tag_valid_d;
    logic        tag_ext_q, tag_ext_d;
    logic [15:0] conflict_q, conflict_d;
    logic        gnt_ext, gnt_int;

    always_comb begin
        gnt_ext = 1'b0;
        gnt_int = 1'b0;
        if (!nrst && !clear_i) begin
            if (state_q == S_EXT_FORCED && ext_valid_i) begin
                gnt_ext = 1'b1;
            end else if (int_valid_i && !ext_only_i) begin
                gnt_int = 1'b1;
            end else if (ext_valid_i) begin
                gnt_ext = 1'b1;
            end
        end
    end

    assign ext_ready_o = gnt_ext;
    assign int_ready_o = gnt_int;

    always_comb begin
        mem_en_o    = gnt_ext | gnt_int;
        mem_wen_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt_ext) begin
            mem_wen_o   = ext_wen_i;
            mem_addr_o  = ext_addr_i;
            mem_wdata_o = ext_wdata_i;
        end else if (gnt_int) begin
            mem_wen_o   = int_wen_i;
            mem_addr_o  = int_addr_i;
            mem_wdata_o = int_wdata_i;
        end
    end

    always_comb begin
        starve_d    = 4'd0;
        state_d     = state_q;
        tag_valid_d = mem_en_o && !mem_wen_o;
        tag_ext_d   = gnt_ext;
        conflict_d  = conflict_q;

        if (ext_valid_i && !gnt_ext) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end

        case (state_q)
            S_INT_PRIO:   if (starve_d == LIMIT) state_d = S_EXT_FORCED;
            S_EXT_FORCED: if (gnt_ext || !ext_valid_i) state_d = S_INT_PRIO;
            default:      state_d = S_INT_PRIO;
        endcase

        if (ext_valid_i && int_valid_i && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end

        if (clear_i) begin
            starve_d    = 4'd0;
            state_d     = S_INT_PRIO;
            tag_valid_d = 1'b0;
            tag_ext_d   = 1'b0;
            conflict_d  = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q     <= S_INT_PRIO;
            starve_q    <= 4'd0;
            tag_valid_q <= 1'b0;
            tag_ext_q   <= 1'b0;
            conflict_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tag_valid_q <= tag_valid_d;
            tag_ext_q   <= tag_ext_d;
            conflict_q  <= conflict_d;
        end
    end

    // The SRAM presents read data one cycle after the enable; steer it by the tag.
    assign ext_rvalid_o   = tag_valid_q && tag_ext_q;
    assign int_rvalid_o   = tag_valid_q && !tag_ext_q;
    assign ext_rdata_o    = ext_rvalid_o ? mem_rdata_i : '0;
    assign int_rdata_o    = int_rvalid_o ? mem_rdata_i : '0;
    assign conflict_cnt_o = conflict_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_qracc_actbuf_arbiter.sv
// Bench for qracc_actbuf_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the arbitration rules and a shadow SRAM.
module tb_qracc_actbuf_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          nrst, clear_i, ext_only_i;
    logic          ext_valid_i, ext_wen_i, int_valid_i, int_wen_i;
    logic [AW-1:0] ext_addr_i, int_addr_i;
    logic [DW-1:0] ext_wdata_i, int_wdata_i;
    logic          ext_ready_o, int_ready_o, ext_rvalid_o, int_rvalid_o;
    logic [DW-1:0] ext_rdata_o, int_rdata_o;
    logic          mem_en_o, mem_wen_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;
    logic [15:0]   conflict_cnt_o;
    logic          state_o;

    qracc_actbuf_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .nrst(nrst), .clear_i(clear_i), .ext_only_i(ext_only_i),
        .ext_valid_i(ext_valid_i), .ext_ready_o(ext_ready_o), .ext_wen_i(ext_wen_i),
        .ext_addr_i(ext_addr_i), .ext_wdata_i(ext_wdata_i),
        .ext_rdata_o(ext_rdata_o), .ext_rvalid_o(ext_rvalid_o),
        .int_valid_i(int_valid_i), .int_ready_o(int_ready_o), .int_wen_i(int_wen_i),
        .int_addr_i(int_addr_i), .int_wdata_i(int_wdata_i),
        .int_rdata_o(int_rdata_o), .int_rvalid_o(int_rvalid_o),
        .mem_en_o(mem_en_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .conflict_cnt_o(conflict_cnt_o), .state_o(state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // SRAM: write-first, read data registered one cycle after the enable
    logic [DW-1:0] sram [256];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_wen_o) sram[mem_addr_o] <= mem_wdata_o;
            else           mem_rdata_i      <= sram[mem_addr_o];
        end
    end

    // reference model and scoreboard
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] exp_q[$];
    bit            own_q[$];
    int            losses;
    bit            owed;
    int            m_conf;
    bit            m_gext, m_gint;
    int            n_checks = 0;
    int            n_fail   = 0;

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 'h10) return 32'h0000_00AB;
        return 32'hC3A5_0000 ^ (i * 32'h0001_0203);
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_ext(bit v, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
        ext_valid_i = v; ext_wen_i = w; ext_addr_i = a; ext_wdata_i = d;
    endtask

    task automatic drive_int(bit v, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
        int_valid_i = v; int_wen_i = w; int_addr_i = a; int_wdata_i = d;
    endtask

    task automatic drive_idle();
        drive_ext(0, 0, '0, '0);
        drive_int(0, 0, '0, '0);
        ext_only_i = 1'b0;
        clear_i    = 1'b0;
    endtask

    task automatic model_reset();
        losses = 0; owed = 0; m_conf = 0;
        exp_q.delete(); own_q.delete();
    endtask

    // Called at a negedge with inputs applied: predict and compare combinational outputs.
    task automatic settle();
        logic [DW-1:0] d;
        bit o;
        #1;
        m_gext = 0; m_gint = 0;
        if (!clear_i) begin
            if (owed && ext_valid_i)              m_gext = 1;
            else if (int_valid_i && !ext_only_i)  m_gint = 1;
            else if (ext_valid_i)                 m_gext = 1;
        end
        check_eq("ext_ready", ext_ready_o, m_gext);
        check_eq("int_ready", int_ready_o, m_gint);
        check_eq("mem_en", mem_en_o, m_gext | m_gint);
        check_eq("mem_wen", mem_wen_o, m_gext ? ext_wen_i : m_gint ? int_wen_i : 1'b0);
        check_eq("mem_addr", mem_addr_o, m_gext ? ext_addr_i : m_gint ? int_addr_i : '0);
        check_eq("mem_wdata", mem_wdata_o, m_gext ? ext_wdata_i : m_gint ? int_wdata_i : '0);
        if (exp_q.size() > 0) begin
            d = exp_q[0]; o = own_q[0];
        end else begin
            d = '0; o = 0;
        end
        check_eq("ext_rvalid", ext_rvalid_o, exp_q.size() > 0 && o);
        check_eq("int_rvalid", int_rvalid_o, exp_q.size() > 0 && !o);
        check_eq("ext_rdata", ext_rdata_o, (exp_q.size() > 0 && o) ? d : '0);
        check_eq("int_rdata", int_rdata_o, (exp_q.size() > 0 && !o) ? d : '0);
        check_eq("conflict_cnt", conflict_cnt_o, 64'(m_conf));
        check_eq("state", state_o, owed);
    endtask

    // Cross the active edge, update the model with what was transferred, return at negedge.
    task automatic advance();
        logic [AW-1:0] a;
        @(posedge clk);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(own_q.pop_front());
        end
        if (m_gext || m_gint) begin
            a = m_gext ? ext_addr_i : int_addr_i;
            if (m_gext ? ext_wen_i : int_wen_i) begin
                shadow[a] = m_gext ? ext_wdata_i : int_wdata_i;
            end else begin
                exp_q.push_back(shadow[a]);
                own_q.push_back(m_gext);
            end
        end
        if (clear_i) begin
            losses = 0; owed = 0; m_conf = 0;
        end else begin
            if (ext_valid_i && !m_gext) losses = (losses >= 15) ? 15 : losses + 1;
            else                        losses = 0;
            owed = (losses == LIM);
            if (ext_valid_i && int_valid_i && m_conf < 'hFFFF) m_conf++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        nrst = 1'b1;
        #1;
        check_eq("rst_ext_ready", ext_ready_o, 0);
        check_eq("rst_int_ready", int_ready_o, 0);
        check_eq("rst_mem_en", mem_en_o, 0);
        check_eq("rst_ext_rvalid", ext_rvalid_o, 0);
        check_eq("rst_int_rvalid", int_rvalid_o, 0);
        check_eq("rst_int_rdata", int_rdata_o, 0);
        check_eq("rst_conflict", conflict_cnt_o, 0);
        check_eq("rst_state", state_o, 0);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]  <= init_word(i);
            shadow[i] = init_word(i);
        end
        nrst = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // int-only read of 0x10, returns 0xAB one cycle later
        drive_int(1, 0, 8'h10, '0);
        settle();
        check_eq("r035_int_ready", int_ready_o, 1);
        check_eq("r035_mem_en", mem_en_o, 1);
        check_eq("r035_mem_addr", mem_addr_o, 8'h10);
        advance();
        drive_idle();
        settle();
        check_eq("r035_int_rvalid", int_rvalid_o, 1);
        check_eq("r035_int_rdata", int_rdata_o, 32'hAB);
        check_eq("r035_ext_rvalid", ext_rvalid_o, 0);
        advance();

        // ext write 0x55 to addr 3, int reads it back the next cycle
        drive_ext(1, 1, 8'd3, 32'h55);
        settle();
        advance();
        drive_idle();
        drive_int(1, 0, 8'd3, '0);
        settle();
        check_eq("r038_int_ready", int_ready_o, 1);
        advance();
        drive_idle();
        settle();
        check_eq("r038_int_rdata", int_rdata_o, 32'h55);
        advance();

        // ext_only: ext wins every cycle
        ext_only_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_ext(1, 0, 8'(k), '0);
            drive_int(1, 0, 8'(k + 8), '0);
            settle();
            check_eq("r037_ext_ready", ext_ready_o, 1);
            check_eq("r037_int_ready", int_ready_o, 0);
            advance();
        end
        ext_only_i = 1'b0;

        // clear with both valid, then starvation sequence from a clean slate
        drive_ext(1, 0, 8'd1, '0);
        drive_int(1, 0, 8'd2, '0);
        clear_i = 1'b1;
        settle();
        check_eq("r040_ext_ready", ext_ready_o, 0);
        check_eq("r040_int_ready", int_ready_o, 0);
        advance();
        clear_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_ext(1, 0, 8'(k), '0);
            drive_int(1, 0, 8'(k + 16), '0);
            settle();
            if (k == 0) check_eq("r040_conflict_cleared", conflict_cnt_o, 0);
            check_eq("r036_ext_gnt", ext_ready_o, k == 4);
            check_eq("r036_int_gnt", int_ready_o, k != 4);
            advance();
        end
        drive_idle();
        settle();
        check_eq("r036_conflict", conflict_cnt_o, 6);
        advance();

        // reset one cycle after a read handshake drops the return
        drive_int(1, 0, 8'h10, '0);
        settle();
        advance();
        do_reset();
        settle();
        check_eq("r039_int_rvalid", int_rvalid_o, 0);
        check_eq("r039_conflict", conflict_cnt_o, 0);
        check_eq("r039_state", state_o, 0);
        advance();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive_ext($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      8'($urandom_range(0, 15)), $urandom);
            drive_int($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      8'($urandom_range(0, 15)), $urandom);
            ext_only_i = ($urandom_range(0, 7) == 0);
            clear_i    = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                settle();
                advance();
            end
        end

        drive_idle();
        settle();
        advance();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/qracc_actbuf_arbiter.md
QRACC_ACTBUF_ARBITER -- requirements
Module: qracc_actbuf_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning activation-buffer word-address width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning activation-buffer word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive ext-losing cycles before ext is forced a grant (legal range 1..15).
REQ-004 SHALL have ports clk input 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port nrst input 1, asynchronous active-high reset (asserted = 1).
REQ-006 SHALL have port clear_i input 1, synchronous clear of all state.
REQ-007 SHALL have port ext_only_i input 1; when high, the int requester is never granted.
REQ-008 SHALL have ext request ports: ext_valid_i in 1; ext_ready_o out 1; ext_wen_i in 1; ext_addr_i in ADDR_W; ext_wdata_i in DATA_W.
REQ-009 SHALL have ext read-return ports: ext_rdata_o out DATA_W; ext_rvalid_o out 1.
REQ-010 SHALL have int request ports int_valid_i, int_ready_o, int_wen_i, int_addr_i, int_wdata_i, with the same directions and widths as ext.
REQ-011 SHALL have int read-return ports int_rdata_o and int_rvalid_o, with the same directions and widths as ext.
REQ-012 SHALL have SRAM ports: mem_en_o out 1; mem_wen_o out 1; mem_addr_o out ADDR_W; mem_wdata_o out DATA_W; mem_rdata_i in DATA_W (valid exactly 1 cycle after a read enable).
REQ-013 SHALL have port conflict_cnt_o out 16: count of cycles where both requesters were valid.

Function
REQ-014 SHALL grant at most one requester per cycle; a grant is ready_o=1 to that requester while its valid_i=1, combinational from current inputs and state.
REQ-015 SHALL never assert ready_o to a requester whose valid_i is low; ready_o does not depend on the requester's own wen/addr.
REQ-016 Handshake (valid && ready) SHALL drive mem_en_o=1, with mem_wen_o, mem_addr_o and mem_wdata_o taken from the granted requester the same cycle; with no grant, mem_en_o=0 and the other mem outputs are 0.
REQ-017 SHALL implement a 2-state FSM, S_INT_PRIO (reset state) and S_EXT_FORCED.
REQ-018 In S_INT_PRIO, SHALL grant int if int_valid_i && !ext_only_i, else grant ext if ext_valid_i.
REQ-019 In S_EXT_FORCED, SHALL grant ext if ext_valid_i, else fall back to the S_INT_PRIO rule.
REQ-020 SHALL keep a 4-bit starve counter: increment (saturating at 15) each cycle ext_valid_i=1 without an ext grant; reset to 0 on any ext grant or when ext_valid_i=0.
REQ-021 S_INT_PRIO SHALL go to S_EXT_FORCED on the edge where the post-update starve counter equals STARVE_LIMIT.
REQ-022 S_EXT_FORCED SHALL return to S_INT_PRIO after exactly one ext handshake, or when ext_valid_i drops.
REQ-023 For a read handshake, SHALL register a 1-cycle return tag {valid, owner}; next cycle, route mem_rdata_i to the owner's rdata_o with rvalid_o=1 for exactly one cycle.
REQ-024 The non-owner rdata_o SHALL hold 0, and rvalid_o SHALL never be high on both requesters in the same cycle.
REQ-025 Read return SHALL have no backpressure; back-to-back reads SHALL each return in order, 1 cycle after their handshake.
REQ-026 Writes SHALL produce no rvalid_o.
REQ-027 A read the cycle after a write to the same address SHALL return the new data; the SRAM is write-first, so no bypass is needed in this block.
REQ-028 conflict_cnt_o SHALL increment when ext_valid_i && int_valid_i, saturating at 16'hFFFF, with no wrap.
REQ-029 clear_i SHALL force the state to S_INT_PRIO and zero the starve counter, return tag and conflict count at the next edge.
REQ-030 While clear_i=1, the block SHALL grant nothing.
REQ-031 ext_only_i toggling mid-stream SHALL take effect the same cycle and SHALL NOT cancel a pending read return.

Reset
REQ-032 On nrst=1, asynchronously: state=S_INT_PRIO; starve counter=0; return tag invalid; conflict_cnt_o=0; ext/int rvalid_o=0; rdata_o=0.
REQ-033 ready_o and mem outputs SHALL be 0 while nrst=1.
REQ-034 A read in flight when reset asserts SHALL be dropped, with no rvalid after reset release.

Verification
REQ-035 Bench SHALL cover: int-only read of addr 0x10 (mem holds 0xAB) -> int_ready_o=1 in cycle 0, mem_en_o=1 with addr 0x10 in cycle 0, int_rvalid_o=1 with data 0xAB in cycle 1, ext_rvalid_o=0.
REQ-036 Bench SHALL cover: both valid continuously, STARVE_LIMIT=4 -> int granted in cycles 0-3, ext granted in cycle 4, int in cycle 5; conflict_cnt_o=6 after 6 cycles.
REQ-037 Bench SHALL cover: ext_only_i=1, both valid -> ext granted every cycle, int_ready_o stays 0.
REQ-038 Bench SHALL cover: ext write 0x55 to addr 3, then int read of addr 3 the next cycle -> int_rdata_o=0x55 one cycle after the read handshake.
REQ-039 Bench SHALL cover: nrst pulsed in the cycle after a read handshake -> rvalid_o stays 0, all counters read 0 after release.
REQ-040 Bench SHALL cover: clear_i with both valid -> no ready_o that cycle, conflict_cnt_o=0 the next cycle.
